// File: rtl/if_else_demod_rx_pkg.sv
// Shared constants and types for the if/else segment demodulator.
package if_else_demod_rx_pkg;

    localparam int SEG_W   = 32;  // received segment sample width
    localparam int PCNT_W  = 6;   // popcount of a 32-bit value fits 0..32
    localparam int DELTA_W = 7;   // signed difference of two popcounts, -32..+32

    typedef enum logic {
        ACCUM = 1'b0,  // no word waiting at the output
        HOLD  = 1'b1   // word_valid high, waiting for the consumer
    } state_t;

    typedef logic signed [DELTA_W-1:0] delta_t;

    // Positive when the sample is closer to the "1" reference than the "0" one.
    function automatic delta_t score_delta(input logic [PCNT_W-1:0] d_if,
                                           input logic [PCNT_W-1:0] d_else);
        return delta_t'($signed({1'b0, d_else}) - $signed({1'b0, d_if}));
    endfunction

endpackage

// File: rtl/if_else_demod_rx_if.sv
// Output word handshake between the demodulator and its bit-level consumer.
// valid/ready: a word transfers on a clock edge where word_valid and
// word_ready are both high; output_bits is stable while word_valid is high,
// and word_valid never depends combinationally on word_ready.
interface if_else_demod_rx_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] output_bits;
    logic              word_valid;
    logic              word_ready;

    modport master (output output_bits, output word_valid, input word_ready);
    modport slave  (input output_bits, input word_valid, output word_ready);
endinterface

// File: rtl/if_else_popcount32.sv
// Combinational population count of one 32-bit segment.
module if_else_popcount32
    import if_else_demod_rx_pkg::*;
(
    input  logic [SEG_W-1:0]  value,
    output logic [PCNT_W-1:0] count
);

    // Sum the set bits of the input word.
    always_comb begin
        count = '0;
        for (int i = 0; i < SEG_W; i++) begin
            count = count + PCNT_W'(value[i]);
        end
    end

endmodule

// File: rtl/if_else_demod_rx.sv
// Receive side of the if/else modulation segment: scores each sample against
// both references, decides one bit per symbol and packs bits into words.
module if_else_demod_rx
    import if_else_demod_rx_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 4,
    parameter int WORD_W          = 32,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEG_W-1:0]   segment_in,
    input  logic               sample_valid,
    input  logic               frame_start,
    input  logic [SEG_W-1:0]   array_ref_wire_1,
    input  logic [SEG_W-1:0]   array_ref_m_wire_1,
    if_else_demod_rx_if.master out_if,
    output logic               overflow,
    output state_t             state_dbg
);

    localparam int SC_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(WORD_W - 1);

    logic [PCNT_W-1:0]         d_if;
    logic [PCNT_W-1:0]         d_else;
    delta_t                    delta;

    logic signed [SCORE_W-1:0] score;
    logic [SC_W-1:0]           sample_cnt;
    logic [BC_W-1:0]           bit_cnt;
    logic [WORD_W-1:0]         shift_reg;

    logic                      restart;
    logic signed [SCORE_W-1:0] score_base;
    logic signed [SCORE_W-1:0] score_sum;
    logic [SC_W-1:0]           sc_base;
    logic [BC_W-1:0]           bc_base;
    logic [WORD_W-1:0]         word_full;
    logic                      symbol_end;
    logic                      word_done;
    logic                      bit_dec;

    state_t                    state;
    logic [WORD_W-1:0]         out_bits_r;
    logic                      word_valid_r;
    logic                      overflow_r;

    if_else_popcount32 u_pc_if   (.value(segment_in ^ array_ref_wire_1),   .count(d_if));
    if_else_popcount32 u_pc_else (.value(segment_in ^ array_ref_m_wire_1), .count(d_else));

    assign delta = score_delta(d_if, d_else);

    // Working view of this sample: a frame start discards the partial word
    // so the sample lands as sample 0 of bit 0.
    always_comb begin
        restart    = sample_valid & frame_start;
        score_base = restart ? '0 : score;
        sc_base    = restart ? '0 : sample_cnt;
        bc_base    = restart ? '0 : bit_cnt;
        score_sum  = score_base + {{(SCORE_W-DELTA_W){delta[DELTA_W-1]}}, delta};
        symbol_end = sample_valid && (sc_base == LAST_SAMPLE);
        word_done  = symbol_end && (bc_base == LAST_BIT);
        // Tie decides 1, as a true condition selects the if section.
        bit_dec    = ~score_sum[SCORE_W-1];
        word_full  = restart ? '0 : shift_reg;
        word_full[bc_base] = bit_dec;
    end

    // Sample path: accumulate, decide, shift; never stalled by the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            score      <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else if (sample_valid) begin
            if (symbol_end) begin
                score      <= '0;
                sample_cnt <= '0;
                shift_reg  <= word_done ? '0 : word_full;
                bit_cnt    <= word_done ? '0 : bc_base + BC_W'(1);
            end else begin
                score      <= score_sum;
                sample_cnt <= sc_base + SC_W'(1);
                shift_reg  <= word_full;
                bit_cnt    <= bc_base;
            end
        end
    end

    // Output buffer FSM with registered word_valid/output_bits/overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            out_bits_r   <= '0;
            word_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (word_done) begin
                        out_bits_r   <= word_full;
                        word_valid_r <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_if.word_ready) begin
                        if (word_done) begin
                            out_bits_r <= word_full;
                        end else begin
                            word_valid_r <= 1'b0;
                            state        <= ACCUM;
                        end
                    end else if (word_done) begin
                        // Held word wins; the new one is dropped.
                        overflow_r <= 1'b1;
                    end
                end
                default: begin
                    state        <= ACCUM;
                    word_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.output_bits = out_bits_r;
    assign out_if.word_valid  = word_valid_r;
    assign overflow           = overflow_r;
    assign state_dbg          = state;

endmodule

// File: tb/tb_if_else_demod_rx.sv
// Self-checking bench for if_else_demod_rx: directed scenarios plus a
// randomized run against a sample-level arithmetic reference model.
module tb_if_else_demod_rx;
    import if_else_demod_rx_pkg::*;

    localparam int SPB = 4;
    localparam int WW  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] segment_in   = '0;
    logic        sample_valid = 1'b0;
    logic        frame_start  = 1'b0;
    logic [31:0] ref_v        = '0;
    logic [31:0] refm_v       = '0;
    logic        overflow;
    state_t      state_dbg;

    if_else_demod_rx_if #(.WORD_W(WW)) bus ();

    if_else_demod_rx #(.SAMPLES_PER_BIT(SPB), .WORD_W(WW), .SCORE_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .segment_in         (segment_in),
        .sample_valid       (sample_valid),
        .frame_start        (frame_start),
        .array_ref_wire_1   (ref_v),
        .array_ref_m_wire_1 (refm_v),
        .out_if             (bus),
        .overflow           (overflow),
        .state_dbg          (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [WW-1:0] exp_q[$];

    int          m_acc, m_scnt, m_bcnt;
    logic [31:0] m_bits, m_out;
    logic        m_valid, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_scnt = 0; m_bcnt = 0; m_bits = '0;
        m_out = '0; m_valid = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Apply one cycle of inputs, advance the model, check outputs after the edge.
    task automatic step(input logic v, input logic fs, input logic [31:0] seg, input logic rdy);
        bit          done;
        logic [31:0] word;
        logic        xfer;
        done = 1'b0;
        word = '0;
        sample_valid   = v;
        frame_start    = fs;
        segment_in     = seg;
        bus.word_ready = rdy;
        if (v) begin
            if (fs) begin
                m_acc = 0; m_scnt = 0; m_bcnt = 0; m_bits = '0;
            end
            m_acc = m_acc + $countones(seg ^ refm_v) - $countones(seg ^ ref_v);
            m_scnt++;
            if (m_scnt == SPB) begin
                m_bits[m_bcnt] = (m_acc >= 0);
                m_acc  = 0;
                m_scnt = 0;
                m_bcnt++;
                if (m_bcnt == WW) begin
                    done   = 1'b1;
                    word   = m_bits;
                    m_bits = '0;
                    m_bcnt = 0;
                end
            end
        end
        xfer = m_valid && rdy;
        if (done && (!m_valid || xfer)) begin
            m_out   = word;
            m_valid = 1'b1;
            exp_q.push_back(word);
        end else begin
            if (done) m_ovf = 1'b1;
            if (xfer) m_valid = 1'b0;
        end
        if (bus.word_valid === 1'b1 && rdy) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL xfer_unexpected observed=%h expected=none", bus.output_bits);
            end
            if (exp_q.size() > 0) check("xfer_word", bus.output_bits, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        check("word_valid", {31'b0, bus.word_valid}, {31'b0, m_valid});
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check("state_hold", {31'b0, state_dbg == HOLD}, {31'b0, m_valid});
        if (m_valid) check("output_bits", bus.output_bits, m_out);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        frame_start = 1'b0;
        bus.word_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("rst_output_bits", bus.output_bits, 32'h0);
        check("rst_word_valid", {31'b0, bus.word_valid}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        check("rst_state", {31'b0, state_dbg == HOLD}, 32'h0);
    endtask

    // mode 0: all samples of a symbol from one reference
    // mode 1: 3 majority + 1 minority sample at a random position
    // mode 2: all-zero samples (tie every symbol)
    task automatic send_word(input logic [31:0] bits, input int mode, input logic fs,
                             input logic rdy, input logic rdy_last);
        logic [31:0] seg;
        int          minor;
        for (int k = 0; k < WW; k++) begin
            minor = $urandom_range(0, SPB - 1);
            for (int s = 0; s < SPB; s++) begin
                case (mode)
                    0: seg = bits[k] ? ref_v : refm_v;
                    1: seg = ((s == minor) ^ bits[k]) ? ref_v : refm_v;
                    default: seg = 32'h0;
                endcase
                step(1'b1, fs && k == 0 && s == 0, seg,
                     (k == WW - 1 && s == SPB - 1) ? rdy_last : rdy);
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] pat;
        logic        v;
        @(negedge clk);
        do_reset();

        // All-ones word, word_ready high throughout.
        ref_v = 32'hFFFF0000;
        refm_v = 32'h0000FFFF;
        send_word(32'hFFFFFFFF, 0, 1'b1, 1'b1, 1'b1);
        check("ones_valid", {31'b0, bus.word_valid}, 32'h1);
        check("ones_word", bus.output_bits, 32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, 1'b1);
        check("ones_valid_drop", {31'b0, bus.word_valid}, 32'h0);

        // Alternating symbols, first symbol is 0.
        send_word(32'hAAAAAAAA, 0, 1'b0, 1'b1, 1'b1);
        check("alt_word", bus.output_bits, 32'hAAAAAAAA);
        step(1'b0, 1'b0, '0, 1'b1);

        // Ties decide 1.
        send_word(32'h0, 2, 1'b0, 1'b1, 1'b1);
        check("tie_word", bus.output_bits, 32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, 1'b1);

        // Majority 3:1 per symbol.
        pat = $urandom();
        send_word(pat, 1, 1'b0, 1'b1, 1'b1);
        check("majority_word", bus.output_bits, pat);
        step(1'b0, 1'b0, '0, 1'b1);

        // Backpressure: second word dropped, overflow sticky.
        do_reset();
        send_word(32'hFFFFFFFF, 0, 1'b0, 1'b0, 1'b0);
        check("bp_word_a", bus.output_bits, 32'hFFFFFFFF);
        check("bp_ovf_before", {31'b0, overflow}, 32'h0);
        send_word(32'h00000000, 0, 1'b0, 1'b0, 1'b0);
        check("bp_word_kept", bus.output_bits, 32'hFFFFFFFF);
        check("bp_ovf_set", {31'b0, overflow}, 32'h1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("bp_valid_drop", {31'b0, bus.word_valid}, 32'h0);
        check("bp_ovf_sticky", {31'b0, overflow}, 32'h1);

        // Transfer and new-word load on the same edge.
        do_reset();
        send_word(32'h12345678, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h9ABCDEF0, 0, 1'b0, 1'b0, 1'b1);
        check("sim_valid", {31'b0, bus.word_valid}, 32'h1);
        check("sim_word", bus.output_bits, 32'h9ABCDEF0);
        check("sim_ovf", {31'b0, overflow}, 32'h0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset in the middle of a word.
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, ref_v, 1'b1);
        do_reset();
        send_word(32'hFFFFFFFF, 0, 1'b0, 1'b1, 1'b1);
        check("midrst_word", bus.output_bits, 32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, 1'b1);

        // frame_start in the middle of a word discards the partial bits.
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, refm_v, 1'b1);
        send_word(32'hFFFFFFFF, 0, 1'b1, 1'b1, 1'b1);
        check("midfs_word", bus.output_bits, 32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, 1'b1);

        // frame_start without sample_valid is ignored.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, ref_v, 1'b1);
        step(1'b0, 1'b1, refm_v, 1'b1);
        send_word(32'h0, 0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic with changing references.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            ref_v  = $urandom();
            refm_v = $urandom();
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: pat = ref_v;
                1: pat = refm_v;
                2: pat = (ref_v & 32'hFFFF00FF) | (refm_v & 32'h0000FF00);
                default: pat = $urandom();
            endcase
            step(v, v && ($urandom_range(0, 299) == 0), pat, ($urandom_range(0, 2) != 0));
            if (n == 2000) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_else_demod_rx.md
Name: if_else_demod_rx

Overview:
- Receive-side counterpart of the generated if/else modulation segment.
- The transmit segment drives `array_ref_wire_1` when the condition bit is 1 and `array_ref_m_wire_1` when it is 0.
- This block takes the received 32-bit segment samples and scores each one against both references. It decides one bit per symbol period and packs the decided bits into an output word with a ready/valid handshake.
- It sits downstream of the channel/segment combine stage and feeds bit-level consumers.

Parameters:
- SAMPLES_PER_BIT, 4, valid samples per symbol (≥1).
- WORD_W, 32, decided bits per output word.
- SCORE_W, 16, signed accumulator width; must hold ±32·SAMPLES_PER_BIT.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- segment_in  input  32  received segment sample.
- sample_valid  input  1  segment_in valid this cycle.
- frame_start  input  1  qualified by sample_valid; this sample is sample 0 of bit 0 of a new word.
- array_ref_wire_1  input  32  reference for bit = 1 (if section).
- array_ref_m_wire_1  input  32  reference for bit = 0 (else section).
- output_bits  output  WORD_W  decided word; bit k = k-th decided symbol.
- word_valid  output  1  output_bits holds an unconsumed word.
- word_ready  input  1  consumer accepts the word.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- **Per accepted sample** (sample_valid=1):
  - d_if = popcount(segment_in ^ array_ref_wire_1).
  - d_else = popcount(segment_in ^ array_ref_m_wire_1).
  - delta = d_else − d_if, signed, range −32..+32.
  - score += delta.
- **Counters:** sample_cnt runs 0..SAMPLES_PER_BIT−1; bit_cnt runs 0..WORD_W−1. Both advance only on accepted samples.
- **Symbol decision** on the sample where sample_cnt = SAMPLES_PER_BIT−1:
  - bit = (score + delta ≥ 0) ? 1 : 0. A tie decides 1, matching condition-true selecting the if section.
  - The bit is written into shift-register position bit_cnt.
  - score and sample_cnt clear at the same edge.
- **Word completion:** when the decided bit has bit_cnt = WORD_W−1, the full word (including this bit) goes to the output buffer at that edge and bit_cnt wraps to 0.
  - word_valid rises in the next cycle. Latency is 1 clk after the last sample of the word.
- **State machine:**
  - ACCUM: normal operation.
  - HOLD: word_valid=1, waiting for word_ready.
  - Accumulation continues in both states; the sample path is never stalled.
- **Output handshake:**
  - A transfer occurs when word_valid && word_ready. word_valid drops the next cycle unless a new word loads in the same cycle.
  - output_bits stays stable while word_valid=1.
- **Simultaneous events:**
  - Transfer and new-word completion in the same cycle: the new word loads, word_valid stays 1, no overflow.
  - New word completes while HOLD with word_ready=0: the new word is discarded, the held word is kept, and overflow is set to 1. overflow clears only on reset.
- **frame_start with sample_valid:**
  - Partial score, sample_cnt and bit_cnt are discarded.
  - That sample is processed as sample 0 of bit 0.
  - The output buffer is unaffected.
- **frame_start without sample_valid:** ignored.
- **Reset (any time, including mid-word):**
  - output_bits=0, word_valid=0, overflow=0.
  - score, counters and shift register cleared; partial word lost; state ACCUM.
- References may change at any time and are sampled with each accepted sample.

Decomposition:
- **Shared package:**
  - SEG_W=32 and the popcount width constant (6 bits).
  - State enum {ACCUM, HOLD}.
  - Signed delta type (7 bits).
- **One sub-module:** if_else_popcount32, a combinational 32-bit popcount. It is instantiated twice, once per reference.
- Remainder is roughly 200 lines of RTL.

Test Plan:
- **All-ones word:** ref=0xFFFF0000, ref_m=0x0000FFFF, SAMPLES_PER_BIT=4, word_ready=1; frame_start then 128 samples of 0xFFFF0000 → output_bits=0xFFFFFFFF; word_valid=1 exactly one cycle after the 128th sample, for 1 cycle.
- **Alternating symbols:** symbols alternate (ref_m ×4, ref ×4) ×16 → output_bits=0xAAAAAAAA.
- **Tie and majority:** every sample 0x00000000 (d_if=d_else=16) → 0xFFFFFFFF. Each symbol as 3×ref + 1×ref_m → bit 1; 1×ref + 3×ref_m → bit 0.
- **Backpressure/overflow:** word_ready=0; send word A=0xFFFFFFFF then B=0x00000000 → output_bits stays 0xFFFFFFFF, overflow=1 on the cycle after B completes. Raise word_ready → A transfers, word_valid=0, overflow stays 1.
- **Simultaneous transfer/load:** word_ready pulses on the same cycle a new word completes → word_valid stays 1, output_bits = new word, overflow=0.
- **Mid-word disruption:**
  - reset after 50 samples → all outputs 0 next cycle; the following 128 ref samples yield 0xFFFFFFFF.
  - Repeat with frame_start at sample 50 instead of reset → same result, the partial bits are discarded.
